monobit_stim_gen: RTL
=====================

// Module: monobit_stim_gen
// PURPOSE
//  Bit-stream source for the monobit frequency tester: emits one block of BLOCK_LEN bits per start,
//  on a valid/ready serial interface. It is the producer end of the tester's bit input.
//  It also reports the exact ones count of the block, so benches and on-chip self-test can check the tester's verdict.
//  Sits between the ui_in control pins and the tester's bit port inside tt_um_monobit.
// PARAMETERS
//  BLOCK_LEN  128      bits per block (2..65535)
//  CNT_W      16       width of index and ones counters (must hold BLOCK_LEN)
//  SEED_W     16       LFSR width (fixed polynomial below; only 16 supported)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       reset, asynchronous, active-low
//  ena          in   1       global enable; low = freeze all state, outputs hold
//  start        in   1       pulse in IDLE starts a block
//  mode         in   2       00 zeros, 01 ones, 10 alternating (1 first), 11 LFSR
//  seed         in   16      LFSR seed, latched on start
//  bias         in   4       only when MONOBIT_STIM_BIAS_EN defined: ones density for mode 11
//  bit_out      out  1       stream bit
//  bit_valid    out  1       bit_out is valid
//  bit_ready    in   1       consumer accepts when bit_valid & bit_ready
//  block_first  out  1       qualifies bit_out as bit index 0
//  block_last   out  1       qualifies bit_out as bit index BLOCK_LEN-1
//  busy         out  1       high in RUN
//  done         out  1       one-cycle pulse after last bit accepted
//  ones_count   out  CNT_W   ones accepted in current/last block
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, idx=0, lfsr=16'hACE1, latched mode=00.
//  FSM: IDLE -start-> RUN -last accept-> DONE -> IDLE (DONE lasts exactly 1 cycle; done=1 there).
//  On start in IDLE: latch mode/seed; clear idx and ones_count.
//   Next cycle: bit_valid=1, block_first=1, busy=1.
//   start in RUN/DONE is ignored; mode/seed changes after start are ignored.
//  Handshake: bit_valid rises and stays high in RUN; bit_out/block_first/block_last stable while valid & !ready.
//   Accept = valid & ready; on accept: idx++, ones_count += bit_out, generator advances.
//   A new bit is presented the next cycle (zero-bubble, 1 bit/cycle at ready=1).
//  Last accept (idx==BLOCK_LEN-1): bit_valid=0 next cycle, state DONE; ones_count holds until next start.
//  Generators: 00 const 0; 01 const 1; 10 bit = ~idx[0];
//   11 Galois LFSR x^16+x^14+x^13+x^11+1, bit = lfsr[0], shift on accept.
//   seed==0 replaced by 16'hACE1 (lock-up guard).
//  ena=0: no state/counter/LFSR update, outputs hold; accept not taken even if ready=1.
//  rst_n low mid-block: immediate return to reset values; partial block discarded, no done.
//  ones_count never exceeds BLOCK_LEN; idx never wraps within a block.
// CONFIGURATION
//  MONOBIT_STIM_BIAS_EN defined: bias port exists; mode 11 bit = (lfsr[3:0] < bias).
//   bias=0 -> all zeros, bias=8 -> ~50%, bias=15 -> ~94% ones; LFSR still advances on accept.
//  Undefined: no bias port; mode 11 bit = lfsr[0].
// TESTING
//  mode=01, ready=1, start pulse -> 128 consecutive valid bits =1; first flagged on bit0, last on bit127;
//   done 1 cycle after; ones_count=128.
//  mode=10, ready=1 -> sequence 1,0,1,0...; ones_count=64; busy low after done.
//  mode=11, seed=0 vs seed=16'hACE1 -> identical streams, first bit=1;
//   ready toggled 1/0 every cycle -> same stream, bit held stable while ready=0.
//  Reset asserted after 50 accepts in mode 01 -> bit_valid=0, ones_count=0, busy=0 immediately;
//   new start gives full 128-bit block.
//  ena=0 for 10 cycles mid-block with ready=1 -> no accepts, bit_out/idx/ones_count frozen; resumes correctly.
//  MONOBIT_STIM_BIAS_EN, mode=11, bias=0 -> ones_count=0; bias=15 -> ones_count>=100 for seed ACE1.

Source files
------------

// File: rtl/monobit_stim_gen.sv
// monobit_stim_gen: one BLOCK_LEN-bit block per start (zeros/ones/alternating/LFSR) plus exact ones count.
// Latency: first bit valid 1 cycle after start, 1 bit/cycle at ready=1, done 1 cycle after last accept.
// Backpressure: bit held stable while !bit_ready or !ena. MONOBIT_STIM_BIAS_EN adds bias port for mode 11.
module monobit_stim_gen #(
    parameter int BLOCK_LEN = 128,
    parameter int CNT_W     = 16,
    parameter int SEED_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [SEED_W-1:0] seed,
`ifdef MONOBIT_STIM_BIAS_EN
    input  logic [3:0]        bias,
`endif
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              block_first,
    output logic              block_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ones_count
);

    localparam logic [SEED_W-1:0] LFSR_INIT = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [SEED_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  ones_q;
    logic [SEED_W-1:0] lfsr_q;
    logic [SEED_W-1:0] lfsr_next;
    logic [1:0]        mode_q;
    logic              gen_bit;
    logic              is_last;
    logic              launch;
    logic              accept;

    assign is_last    = (idx_q == LAST_IDX);
    assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign ones_count = ones_q;

    always_comb begin
        gen_bit = 1'b0;
        case (mode_q)
            2'b00:   gen_bit = 1'b0;
            2'b01:   gen_bit = 1'b1;
            2'b10:   gen_bit = ~idx_q[0];
`ifdef MONOBIT_STIM_BIAS_EN
            default: gen_bit = (lfsr_q[3:0] < bias);
`else
            default: gen_bit = lfsr_q[0];
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        accept      = 1'b0;
        bit_valid   = 1'b0;
        bit_out     = 1'b0;
        block_first = 1'b0;
        block_last  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                launch = start & ena;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                bit_valid   = 1'b1;
                busy        = 1'b1;
                bit_out     = gen_bit;
                block_first = (idx_q == '0);
                block_last  = is_last;
                accept      = bit_ready & ena;
                if (bit_ready && is_last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // idx stops at the last index so it never wraps, even at BLOCK_LEN = 2^CNT_W - 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ones_q <= '0;
            lfsr_q <= LFSR_INIT;
            mode_q <= 2'b00;
        end else if (launch) begin
            idx_q  <= '0;
            ones_q <= '0;
            mode_q <= mode;
            lfsr_q <= (seed == '0) ? LFSR_INIT : seed;
        end else if (accept) begin
            ones_q <= ones_q + {{(CNT_W-1){1'b0}}, gen_bit};
            lfsr_q <= lfsr_next;
            if (!is_last) idx_q <= idx_q + 1'b1;
        end
    end

endmodule
